cpu_bus_mem_model: RTL and testbench
====================================

Name: cpu_bus_mem_model

Overview:
- Synthesizable, parametrised memory/bus responder for the cpu core's two buses.
- Replaces fixed constant drive of Prog_BUS_READ / Data_BUS_READ with real storage: a program memory (loadable) and a data RAM.
- Provides configurable read latency, valid strobes, a write counter and a sticky out-of-range flag.
- Sits beside cpu in simulation tops and FPGA bring-up builds; cpu ports connect one-to-one.

Parameters:
- DATA_W, 32, bus word width.
- ADDR_W, 32, address bus width. Addresses are byte addresses; word index = ADDR[ADDR_W-1:2].
- PROG_DEPTH, 256, program memory words.
- DATA_DEPTH, 256, data RAM words.
- READ_LAT, 1, cycles from request edge to data; legal range 1..4.
- CNT_W, 16, write counter width.
- DEFAULT_PROG, 32'h0000064f, Prog_BUS_READ value at reset and on out-of-range reads.
- DEFAULT_DATA, 32'h000022b4, Data_BUS_READ value at reset and on out-of-range reads.

Ports:
- CLK  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- ADDR_Prog  in  ADDR_W  program fetch byte address.
- CS_P  in  1  program fetch request.
- Prog_BUS_READ  out  DATA_W  fetched instruction word.
- Prog_valid  out  1  one-cycle strobe: Prog_BUS_READ is new.
- ADDR  in  ADDR_W  data byte address.
- CS  in  1  data access request.
- WE  in  1  write enable; qualifies CS.
- Data_BUS_WRITE  in  DATA_W  store data.
- Data_BUS_READ  out  DATA_W  load data.
- Data_valid  out  1  one-cycle strobe: Data_BUS_READ is new.
- load_en  in  1  program memory load strobe.
- load_addr  in  ADDR_W  word index for load.
- load_data  in  DATA_W  word to load.
- wr_count  out  CNT_W  accepted data writes since reset.
- err_oob  out  1  sticky out-of-range flag.

Behaviour:
Reset (reset=0, asynchronous):
- Prog_BUS_READ=DEFAULT_PROG; Data_BUS_READ=DEFAULT_DATA.
- Prog_valid=0; Data_valid=0; wr_count=0; err_oob=0.
- Both latency pipelines cleared. Memory arrays are not reset.
- Reset mid-operation discards in-flight reads; no valid strobe follows reset release.

Program read:
- CS_P=1 and load_en=0 at an edge starts a read of PROG_DEPTH index ADDR_Prog[..:2].
- Data and Prog_valid appear READ_LAT edges later.
- Fully pipelined: one request per cycle, returned in order.
- Prog_BUS_READ holds its last value between strobes.

Data access:
- CS=1, WE=1: write Data_BUS_WRITE at the edge. No Data_valid. wr_count +1, saturating at all-ones.
- CS=1, WE=0: read, pipelined identically to program reads.
- A read issued the cycle after a write to the same index returns the new data (write-first RAM).
- WE with CS=0 is ignored.

Out of range (index >= depth, either bus):
- Write is dropped and wr_count is unchanged.
- Read returns the DEFAULT_* value with a normal valid strobe.
- err_oob is set and held until reset.

Loading:
- load_en=1 writes load_data at load_addr at the edge.
- A fetch on the same cycle is ignored: no valid strobe, no error.
- Out-of-range load sets err_oob.

Simultaneous events:
- Program and data paths are independent; both may strobe on the same cycle.

Decomposition:
- Shared package cpu_bus_pkg: DEFAULT_PROG/DEFAULT_DATA constants, word-index extraction function, READ_LAT range constants.
- One natural sub-module, rd_lat_pipe, parametrised by DATA_W and READ_LAT: valid + data shift pipeline with async clear. Instantiated twice.

Test Plan:
- Reset hold for 100 ns, then release, no requests -> Prog_BUS_READ=32'h064f, Data_BUS_READ=32'h22b4, both valids 0, wr_count=0, err_oob=0.
- Load prog words 0..3 = 32'h20080005, 32'h20090003, 32'h01095020, 32'hac0a0010; then CS_P on addresses 0,4,8,12 on back-to-back cycles with READ_LAT=2 -> 4 consecutive Prog_valid strobes, first strobe 2 cycles after the first request, words returned in order.
- Write 32'hdeadbeef to address 0x40, then read 0x40 on the next cycle -> Data_BUS_READ=32'hdeadbeef after READ_LAT; wr_count=1.
- Read address 0x400 with DATA_DEPTH=256 -> Data_BUS_READ=32'h22b4 with Data_valid; err_oob=1 and still 1 after 10 idle cycles. Write to 0x400 -> wr_count unchanged.
- Issue CS_P read with READ_LAT=3, assert reset 1 cycle later -> no Prog_valid after release, outputs at reset values.
- CNT_W=4: 20 writes -> wr_count stops at 15. Simultaneous CS_P read and CS data read -> both valids strobe on the same cycle.

Source files
------------

// File: rtl/cpu_bus_pkg.sv
// rtl/cpu_bus_pkg.sv - shared constants and helpers for the cpu bus memory model
package cpu_bus_pkg;

  localparam logic [31:0] DEFAULT_PROG = 32'h0000064f;
  localparam logic [31:0] DEFAULT_DATA = 32'h000022b4;

  localparam int READ_LAT_MIN = 1;
  localparam int READ_LAT_MAX = 4;

  // Indices are carried at a fixed wide width so range checks never truncate.
  localparam int IDX_W = 64;

  function automatic logic [IDX_W-1:0] word_index(input logic [IDX_W-1:0] byte_addr);
    return byte_addr >> 2;
  endfunction

  function automatic int clamp_lat(input int lat);
    if (lat < READ_LAT_MIN) return READ_LAT_MIN;
    if (lat > READ_LAT_MAX) return READ_LAT_MAX;
    return lat;
  endfunction

endpackage

// File: rtl/rd_lat_pipe.sv
// rtl/rd_lat_pipe.sv - valid/data shift pipeline; output holds its last delivered word
module rd_lat_pipe
  import cpu_bus_pkg::*;
#(
  parameter int                 DATA_W    = 32,
  parameter int                 READ_LAT  = 1,
  parameter logic [DATA_W-1:0]  RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  localparam int LAT = clamp_lat(READ_LAT);
  // Stage 0 captures at the request edge, so the last stage updates LAT edges later.
  localparam int N   = LAT + 1;

  logic [N-1:0]      valid_q, valid_d;
  logic [DATA_W-1:0] data_q [N];
  logic [DATA_W-1:0] data_d [N];
  logic [N-1:0]      v_in;
  logic [DATA_W-1:0] d_in   [N];

  always_comb begin
    v_in    = '0;
    valid_d = '0;
    for (int i = 0; i < N; i++) begin
      d_in[i]   = '0;
      data_d[i] = '0;
    end
    v_in[0] = in_valid;
    d_in[0] = in_data;
    for (int i = 1; i < N; i++) begin
      v_in[i] = valid_q[i-1];
      d_in[i] = data_q[i-1];
    end
    // Stages only load on a valid word, which gives the hold-between-strobes behaviour.
    for (int i = 0; i < N; i++) begin
      valid_d[i] = v_in[i];
      data_d[i]  = v_in[i] ? d_in[i] : data_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < N; i++) data_q[i] <= RESET_VAL;
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < N; i++) data_q[i] <= data_d[i];
    end
  end

  assign out_valid = valid_q[N-1];
  assign out_data  = data_q[N-1];

endmodule

// File: rtl/cpu_bus_mem_model.sv
// rtl/cpu_bus_mem_model.sv - program memory and data RAM responder for the cpu buses
module cpu_bus_mem_model
  import cpu_bus_pkg::*;
#(
  parameter int                DATA_W       = 32,
  parameter int                ADDR_W       = 32,
  parameter int                PROG_DEPTH   = 256,
  parameter int                DATA_DEPTH   = 256,
  parameter int                READ_LAT     = 1,
  parameter int                CNT_W        = 16,
  parameter logic [DATA_W-1:0] DEFAULT_PROG = DATA_W'(cpu_bus_pkg::DEFAULT_PROG),
  parameter logic [DATA_W-1:0] DEFAULT_DATA = DATA_W'(cpu_bus_pkg::DEFAULT_DATA)
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ADDR_Prog,
  input  logic              CS_P,
  output logic [DATA_W-1:0] Prog_BUS_READ,
  output logic              Prog_valid,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic              CS,
  input  logic              WE,
  input  logic [DATA_W-1:0] Data_BUS_WRITE,
  output logic [DATA_W-1:0] Data_BUS_READ,
  output logic              Data_valid,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic [CNT_W-1:0]  wr_count,
  output logic              err_oob
);

  localparam int PA_W = (PROG_DEPTH > 1) ? $clog2(PROG_DEPTH) : 1;
  localparam int DA_W = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;

  logic [DATA_W-1:0] prog_mem [PROG_DEPTH];
  logic [DATA_W-1:0] data_mem [DATA_DEPTH];

  logic [IDX_W-1:0]  prog_idx, data_idx, load_idx;
  logic              prog_in_range, data_in_range, load_in_range;
  logic              prog_req, data_rd, data_wr, prog_we, data_we, oob_hit;
  logic [DATA_W-1:0] prog_rd_data, data_rd_data;
  logic [CNT_W-1:0]  wr_count_q, wr_count_d;
  logic              err_oob_q, err_oob_d;

  always_comb begin
    prog_idx      = word_index(IDX_W'(ADDR_Prog));
    data_idx      = word_index(IDX_W'(ADDR));
    load_idx      = IDX_W'(load_addr);
    prog_in_range = prog_idx < IDX_W'(PROG_DEPTH);
    data_in_range = data_idx < IDX_W'(DATA_DEPTH);
    load_in_range = load_idx < IDX_W'(PROG_DEPTH);

    // A load owns the program port for that cycle; the fetch is dropped silently.
    prog_req = CS_P && !load_en;
    data_rd  = CS && !WE;
    data_wr  = CS && WE;
    prog_we  = load_en && load_in_range;
    data_we  = data_wr && data_in_range;

    prog_rd_data = prog_in_range ? prog_mem[prog_idx[PA_W-1:0]] : DEFAULT_PROG;
    data_rd_data = data_in_range ? data_mem[data_idx[DA_W-1:0]] : DEFAULT_DATA;

    oob_hit   = (prog_req && !prog_in_range) || (CS && !data_in_range) ||
                (load_en && !load_in_range);
    err_oob_d = err_oob_q | oob_hit;

    wr_count_d = wr_count_q;
    if (data_we && (wr_count_q != '1)) wr_count_d = wr_count_q + CNT_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (prog_we) prog_mem[load_idx[PA_W-1:0]] <= load_data;
    if (data_we) data_mem[data_idx[DA_W-1:0]] <= Data_BUS_WRITE;
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      wr_count_q <= '0;
      err_oob_q  <= 1'b0;
    end else begin
      wr_count_q <= wr_count_d;
      err_oob_q  <= err_oob_d;
    end
  end

  rd_lat_pipe #(
    .DATA_W   (DATA_W),
    .READ_LAT (READ_LAT),
    .RESET_VAL(DEFAULT_PROG)
  ) u_prog_pipe (
    .clk      (CLK),
    .rst_n    (reset),
    .in_valid (prog_req),
    .in_data  (prog_rd_data),
    .out_valid(Prog_valid),
    .out_data (Prog_BUS_READ)
  );

  rd_lat_pipe #(
    .DATA_W   (DATA_W),
    .READ_LAT (READ_LAT),
    .RESET_VAL(DEFAULT_DATA)
  ) u_data_pipe (
    .clk      (CLK),
    .rst_n    (reset),
    .in_valid (data_rd),
    .in_data  (data_rd_data),
    .out_valid(Data_valid),
    .out_data (Data_BUS_READ)
  );

  assign wr_count = wr_count_q;
  assign err_oob  = err_oob_q;

endmodule

// File: tb/tb_cpu_bus_mem_model.sv
// tb/tb_cpu_bus_mem_model.sv - directed bench for cpu_bus_mem_model (latency 2 and 3 instances)
module tb_cpu_bus_mem_model;

  logic        clk;
  logic        rst_n;
  logic [31:0] addr_prog, addr, wdata, load_addr, load_data;
  logic        cs_p, cs, we, load_en;

  logic [31:0] a_prog_data, a_data_data, b_prog_data, b_data_data;
  logic        a_prog_valid, a_data_valid, b_prog_valid, b_data_valid;
  logic [3:0]  a_wr_count;
  logic [15:0] b_wr_count;
  logic        a_err, b_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] prog_words [4];

  cpu_bus_mem_model #(.READ_LAT(2), .CNT_W(4)) dut_a (
    .CLK(clk), .reset(rst_n),
    .ADDR_Prog(addr_prog), .CS_P(cs_p),
    .Prog_BUS_READ(a_prog_data), .Prog_valid(a_prog_valid),
    .ADDR(addr), .CS(cs), .WE(we), .Data_BUS_WRITE(wdata),
    .Data_BUS_READ(a_data_data), .Data_valid(a_data_valid),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .wr_count(a_wr_count), .err_oob(a_err)
  );

  cpu_bus_mem_model #(.READ_LAT(3), .CNT_W(16)) dut_b (
    .CLK(clk), .reset(rst_n),
    .ADDR_Prog(addr_prog), .CS_P(cs_p),
    .Prog_BUS_READ(b_prog_data), .Prog_valid(b_prog_valid),
    .ADDR(addr), .CS(cs), .WE(we), .Data_BUS_WRITE(wdata),
    .Data_BUS_READ(b_data_data), .Data_valid(b_data_valid),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .wr_count(b_wr_count), .err_oob(b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    prog_words[0] = 32'h20080005;
    prog_words[1] = 32'h20090003;
    prog_words[2] = 32'h01095020;
    prog_words[3] = 32'hac0a0010;

    rst_n = 1'b0;
    addr_prog = '0; addr = '0; wdata = '0; load_addr = '0; load_data = '0;
    cs_p = 1'b0; cs = 1'b0; we = 1'b0; load_en = 1'b0;
    #100;
    rst_n = 1'b1;
    tick();
    check_eq("rst_prog_data", a_prog_data, 32'h0000064f);
    check_eq("rst_data_data", a_data_data, 32'h000022b4);
    check_eq("rst_prog_valid", a_prog_valid, 1'b0);
    check_eq("rst_data_valid", a_data_valid, 1'b0);
    check_eq("rst_wr_count", a_wr_count, 4'd0);
    check_eq("rst_err", a_err, 1'b0);

    for (int i = 0; i < 4; i++) begin
      load_en = 1'b1; load_addr = i; load_data = prog_words[i];
      tick();
    end
    load_en = 1'b0;

    // Back-to-back fetches: A strobes after edges 2..5, B after edges 3..6.
    for (int k = 0; k < 8; k++) begin
      cs_p = (k < 4);
      addr_prog = k * 4;
      tick();
      check_eq($sformatf("a_pv_%0d", k), a_prog_valid, (k >= 2 && k <= 5));
      if (k >= 2 && k <= 5) check_eq($sformatf("a_pd_%0d", k), a_prog_data, prog_words[k-2]);
      check_eq($sformatf("b_pv_%0d", k), b_prog_valid, (k >= 3 && k <= 6));
      if (k >= 3 && k <= 6) check_eq($sformatf("b_pd_%0d", k), b_prog_data, prog_words[k-3]);
    end
    check_eq("prog_hold", a_prog_data, 32'hac0a0010);

    cs = 1'b1; we = 1'b1; addr = 32'h40; wdata = 32'hdeadbeef;
    tick();
    check_eq("wr_no_valid", a_data_valid, 1'b0);
    we = 1'b0;
    tick();
    cs = 1'b0;
    tick();
    check_eq("rd_early_valid", a_data_valid, 1'b0);
    tick();
    check_eq("rd_valid", a_data_valid, 1'b1);
    check_eq("rd_data", a_data_data, 32'hdeadbeef);
    check_eq("wr_count_1", a_wr_count, 4'd1);
    tick();
    check_eq("b_rd_data", b_data_data, 32'hdeadbeef);
    check_eq("b_rd_valid", b_data_valid, 1'b1);

    load_en = 1'b1; load_addr = 5; load_data = 32'h00001234; cs_p = 1'b1; addr_prog = 0;
    tick();
    load_en = 1'b0; cs_p = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("ld_fetch_pv_%0d", k), a_prog_valid, 1'b0);
      tick();
    end
    check_eq("ld_no_err", a_err, 1'b0);
    cs_p = 1'b1; addr_prog = 32'd20;
    tick();
    cs_p = 1'b0;
    tick();
    tick();
    check_eq("ld_word_valid", a_prog_valid, 1'b1);
    check_eq("ld_word_data", a_prog_data, 32'h00001234);

    cs = 1'b1; we = 1'b0; addr = 32'h400;
    tick();
    cs = 1'b0;
    tick();
    tick();
    check_eq("oob_valid", a_data_valid, 1'b1);
    check_eq("oob_data", a_data_data, 32'h000022b4);
    check_eq("oob_err", a_err, 1'b1);
    for (int k = 0; k < 10; k++) tick();
    check_eq("oob_err_sticky", a_err, 1'b1);
    cs = 1'b1; we = 1'b1; addr = 32'h400; wdata = 32'h55;
    tick();
    cs = 1'b0; we = 1'b0;
    check_eq("oob_wr_count", a_wr_count, 4'd1);

    cs_p = 1'b1; addr_prog = 32'd4; cs = 1'b1; we = 1'b0; addr = 32'h40;
    tick();
    cs_p = 1'b0; cs = 1'b0;
    tick();
    tick();
    check_eq("sim_pv", a_prog_valid, 1'b1);
    check_eq("sim_dv", a_data_valid, 1'b1);
    check_eq("sim_pd", a_prog_data, 32'h20090003);
    check_eq("sim_dd", a_data_data, 32'hdeadbeef);

    for (int i = 0; i < 20; i++) begin
      cs = 1'b1; we = 1'b1; addr = 32'h44; wdata = i;
      tick();
    end
    cs = 1'b0; we = 1'b0;
    tick();
    check_eq("sat_a", a_wr_count, 4'd15);
    check_eq("sat_b", b_wr_count, 16'd21);

    // Reset while B (latency 3) still has a fetch in flight.
    cs_p = 1'b1; addr_prog = 32'd8;
    tick();
    cs_p = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_pd", b_prog_data, 32'h0000064f);
    check_eq("mid_rst_pv", b_prog_valid, 1'b0);
    check_eq("mid_rst_cnt", b_wr_count, 16'd0);
    check_eq("mid_rst_err", a_err, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_eq($sformatf("post_rst_pv_%0d", k), b_prog_valid, 1'b0);
    end
    check_eq("post_rst_pd", b_prog_data, 32'h0000064f);
    check_eq("post_rst_dd", b_data_data, 32'h000022b4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
